// File: rtl/microroc_param_distributor.sv
// Per-chain MICROROC slow-control parameter store: shadow writes, one-cycle commit, per-dirty-chain load sequencing.
// Optional readback of shadow fields via command field 0x1E when MICROROC_PARAM_READBACK_EN is defined.
module microroc_param_distributor #(
    parameter int unsigned ASIC_CHAIN_NUMBER = 4,
    parameter int unsigned LOAD_TIMEOUT      = 50000,
    parameter logic [7:0]  CHIP_ID_BASE      = 8'hA1
) (
    input  logic                              Clk,
    input  logic                              reset_n,
    input  logic                              CmdValid,
    input  logic [3:0]                        CmdChain,
    input  logic [4:0]                        CmdField,
    input  logic [15:0]                       CmdData,
    output logic [10*ASIC_CHAIN_NUMBER-1:0]   MicrorocDac0Vth,
    output logic [10*ASIC_CHAIN_NUMBER-1:0]   MicrorocDac1Vth,
    output logic [10*ASIC_CHAIN_NUMBER-1:0]   MicrorocDac2Vth,
    output logic [8*ASIC_CHAIN_NUMBER-1:0]    MicrorocChipID,
    output logic [16*ASIC_CHAIN_NUMBER-1:0]   MicrorocControlWord,
    output logic [192*ASIC_CHAIN_NUMBER-1:0]  MicrorocChannelDiscriminatorMask,
    output logic [ASIC_CHAIN_NUMBER-1:0]      MicrorocParameterLoadStart,
    input  logic [ASIC_CHAIN_NUMBER-1:0]      MicrorocParameterLoadDone,
    output logic                              Busy,
    output logic                              LoadCompletePulse,
    output logic                              CommitError,
    output logic [ASIC_CHAIN_NUMBER-1:0]      LoadTimeoutFlags,
    output logic                              ReadbackValid,
    output logic [15:0]                       ReadbackData
);

    localparam int unsigned N     = ASIC_CHAIN_NUMBER;
    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT);
    localparam logic [9:0]  DAC_RESET = 10'd250;

    typedef enum logic [2:0] {S_IDLE, S_COPY, S_SCAN, S_START, S_WAIT, S_FINISH} state_t;
    state_t state, state_next;

    logic [9:0]  sh_dac0 [N], sh_dac1 [N], sh_dac2 [N];
    logic [7:0]  sh_chip_id [N];
    logic [15:0] sh_ctrl [N];
    logic [15:0] sh_mask [N][12];
    logic [9:0]  act_dac0 [N], act_dac1 [N], act_dac2 [N];
    logic [7:0]  act_chip_id [N];
    logic [15:0] act_ctrl [N];
    logic [15:0] act_mask [N][12];

    logic [N-1:0]     dirty;
    logic [N-1:0]     wr_hit;
    logic [3:0]       cur_chain;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_commit, is_mask, is_write;
    logic [3:0]       mask_word;
    logic             scan_found, done_hit, timeout_hit, wait_exit;
    logic [3:0]       scan_idx;

    assign is_commit = CmdValid && (CmdField == 5'h1F);
    assign is_mask   = (CmdField >= 5'h08) && (CmdField <= 5'h13);
    assign is_write  = CmdValid && (is_mask || (CmdField <= 5'h04));
    assign mask_word = 4'(CmdField - 5'h08);

    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < N; i++)
            wr_hit[i] = is_write && ((CmdChain == 4'hF) || (CmdChain == 4'(i)));
    end

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        done_hit   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (dirty[i] && !scan_found) begin
                scan_found = 1'b1;
                scan_idx   = 4'(i);
            end
            if (cur_chain == 4'(i))
                done_hit = MicrorocParameterLoadDone[i];
        end
    end

    assign timeout_hit = (state == S_WAIT) && !done_hit && (wait_cnt == CNT_W'(LOAD_TIMEOUT - 1));
    assign wait_exit   = (state == S_WAIT) && (done_hit || timeout_hit);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                sh_dac0[i]    <= DAC_RESET;
                sh_dac1[i]    <= DAC_RESET;
                sh_dac2[i]    <= DAC_RESET;
                sh_chip_id[i] <= 8'(CHIP_ID_BASE + 8'(i));
                sh_ctrl[i]    <= '0;
                for (int unsigned w = 0; w < 12; w++)
                    sh_mask[i][w] <= '1;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_hit[i]) begin
                    case (CmdField)
                        5'h00:   sh_dac0[i]    <= CmdData[9:0];
                        5'h01:   sh_dac1[i]    <= CmdData[9:0];
                        5'h02:   sh_dac2[i]    <= CmdData[9:0];
                        5'h03:   sh_chip_id[i] <= CmdData[7:0];
                        5'h04:   sh_ctrl[i]    <= CmdData;
                        default: if (is_mask) sh_mask[i][mask_word] <= CmdData;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                act_dac0[i]    <= DAC_RESET;
                act_dac1[i]    <= DAC_RESET;
                act_dac2[i]    <= DAC_RESET;
                act_chip_id[i] <= 8'(CHIP_ID_BASE + 8'(i));
                act_ctrl[i]    <= '0;
                for (int unsigned w = 0; w < 12; w++)
                    act_mask[i][w] <= '1;
            end
        end else if (state == S_COPY) begin
            act_dac0    <= sh_dac0;
            act_dac1    <= sh_dac1;
            act_dac2    <= sh_dac2;
            act_chip_id <= sh_chip_id;
            act_ctrl    <= sh_ctrl;
            act_mask    <= sh_mask;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (is_commit) state_next = S_COPY;
            S_COPY:   state_next = S_SCAN;
            S_SCAN:   state_next = scan_found ? S_START : S_FINISH;
            S_START:  state_next = S_WAIT;
            S_WAIT:   if (wait_exit) state_next = S_SCAN;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_chain        <= '0;
            wait_cnt         <= '0;
            dirty            <= '0;
            LoadTimeoutFlags <= '0;
            CommitError      <= 1'b0;
        end else begin
            CommitError <= is_commit && (state != S_IDLE);
            if (state == S_SCAN && scan_found)
                cur_chain <= scan_idx;
            if (state == S_START)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            // A write landing in the same cycle as the WAIT exit keeps the chain queued for another load
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_hit[i])
                    dirty[i] <= 1'b1;
                else if (wait_exit && (cur_chain == 4'(i)))
                    dirty[i] <= 1'b0;
            end
            if (is_commit && state == S_IDLE)
                LoadTimeoutFlags <= '0;
            else
                for (int unsigned i = 0; i < N; i++)
                    if (timeout_hit && (cur_chain == 4'(i)))
                        LoadTimeoutFlags[i] <= 1'b1;
        end
    end

    assign Busy              = (state != S_IDLE);
    assign LoadCompletePulse = (state == S_FINISH);

    always_comb begin
        MicrorocParameterLoadStart       = '0;
        MicrorocDac0Vth                  = '0;
        MicrorocDac1Vth                  = '0;
        MicrorocDac2Vth                  = '0;
        MicrorocChipID                   = '0;
        MicrorocControlWord              = '0;
        MicrorocChannelDiscriminatorMask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            MicrorocParameterLoadStart[i] = (state == S_START) && (cur_chain == 4'(i));
            MicrorocDac0Vth[10*i +: 10]    = act_dac0[i];
            MicrorocDac1Vth[10*i +: 10]    = act_dac1[i];
            MicrorocDac2Vth[10*i +: 10]    = act_dac2[i];
            MicrorocChipID[8*i +: 8]       = act_chip_id[i];
            MicrorocControlWord[16*i +: 16] = act_ctrl[i];
            for (int unsigned w = 0; w < 12; w++)
                MicrorocChannelDiscriminatorMask[192*i + 16*w +: 16] = act_mask[i][w];
        end
    end

`ifdef MICROROC_PARAM_READBACK_EN
    logic [4:0]  rb_field;
    logic [3:0]  rb_word;
    logic [15:0] rb_value;

    assign rb_field = CmdData[4:0];
    assign rb_word  = 4'(rb_field - 5'h08);

    // Broadcast never matches a chain index, so it falls through to zero
    always_comb begin
        rb_value = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (CmdChain == 4'(i)) begin
                case (rb_field)
                    5'h00:   rb_value = {6'd0, sh_dac0[i]};
                    5'h01:   rb_value = {6'd0, sh_dac1[i]};
                    5'h02:   rb_value = {6'd0, sh_dac2[i]};
                    5'h03:   rb_value = {8'd0, sh_chip_id[i]};
                    5'h04:   rb_value = sh_ctrl[i];
                    default: if (rb_field >= 5'h08 && rb_field <= 5'h13) rb_value = sh_mask[i][rb_word];
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ReadbackValid <= 1'b0;
            ReadbackData  <= '0;
        end else begin
            ReadbackValid <= CmdValid && (CmdField == 5'h1E);
            if (CmdValid && (CmdField == 5'h1E))
                ReadbackData <= rb_value;
        end
    end
`else
    assign ReadbackValid = 1'b0;
    assign ReadbackData  = '0;
`endif

endmodule

// File: tb/tb_microroc_param_distributor.sv
// Self-checking bench for microroc_param_distributor (4 chains, short load timeout).
// LoadStart pulses are scored against an expected queue filled when each commit is issued.
module tb_microroc_param_distributor;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           CmdValid = 1'b0;
    logic [3:0]     CmdChain = '0;
    logic [4:0]     CmdField = '0;
    logic [15:0]    CmdData = '0;
    logic [10*N-1:0]  Dac0, Dac1, Dac2;
    logic [8*N-1:0]   ChipID;
    logic [16*N-1:0]  Ctrl;
    logic [192*N-1:0] Mask;
    logic [N-1:0]   LoadStart;
    logic [N-1:0]   LoadDone = '0;
    logic           Busy, LoadCompletePulse, CommitError;
    logic [N-1:0]   Flags;
    logic           ReadbackValid;
    logic [15:0]    ReadbackData;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_front;

    microroc_param_distributor #(
        .ASIC_CHAIN_NUMBER(N),
        .LOAD_TIMEOUT(20),
        .CHIP_ID_BASE(8'hA1)
    ) dut (
        .Clk(Clk),
        .reset_n(reset_n),
        .CmdValid(CmdValid),
        .CmdChain(CmdChain),
        .CmdField(CmdField),
        .CmdData(CmdData),
        .MicrorocDac0Vth(Dac0),
        .MicrorocDac1Vth(Dac1),
        .MicrorocDac2Vth(Dac2),
        .MicrorocChipID(ChipID),
        .MicrorocControlWord(Ctrl),
        .MicrorocChannelDiscriminatorMask(Mask),
        .MicrorocParameterLoadStart(LoadStart),
        .MicrorocParameterLoadDone(LoadDone),
        .Busy(Busy),
        .LoadCompletePulse(LoadCompletePulse),
        .CommitError(CommitError),
        .LoadTimeoutFlags(Flags),
        .ReadbackValid(ReadbackValid),
        .ReadbackData(ReadbackData)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (LoadStart !== 4'b0000) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL load_start_unexpected: got %b, required none", LoadStart);
            end else begin
                exp_front = exp_q.pop_front();
                if (LoadStart !== exp_front) begin
                    n_err++;
                    $display("FAIL load_start_order: got %b, required %b", LoadStart, exp_front);
                end
            end
        end
    end

    task automatic drive_cmd(input logic [3:0] ch, input logic [4:0] fld, input logic [15:0] dat);
        @(negedge Clk);
        CmdValid = 1'b1; CmdChain = ch; CmdField = fld; CmdData = dat;
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    task automatic wait_start(input int ch);
        bit seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge Clk);
            if (LoadStart[ch] === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_start[%0d]: got no pulse, required pulse within 100 cycles", ch);
        end
    endtask

    task automatic serve(input int ch, input int d, input bit early);
        wait_start(ch);
        if (early) LoadDone[ch] = 1'b1;
        for (int k = 0; k < d; k++) begin
            @(negedge Clk);
            LoadDone = '0;
            n_vec++;
            if (LoadStart !== 4'b0000) begin
                n_err++;
                $display("FAIL serve_quiet[%0d]: got %b, required 0000", ch, LoadStart);
            end
        end
        LoadDone[ch] = 1'b1;
        @(negedge Clk);
        LoadDone = '0;
    endtask

    task automatic wait_complete();
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge Clk);
            if (LoadCompletePulse === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_complete: got no pulse, required pulse within 200 cycles");
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_id;
        for (int i = 0; i < N; i++) begin
            exp_id = 8'hA1 + 8'(i);
            n_vec += 6;
            if (Dac0[10*i +: 10] !== 10'd250) begin n_err++; $display("FAIL reset_dac0[%0d]: got %0d, required 250", i, Dac0[10*i +: 10]); end
            if (Dac1[10*i +: 10] !== 10'd250) begin n_err++; $display("FAIL reset_dac1[%0d]: got %0d, required 250", i, Dac1[10*i +: 10]); end
            if (Dac2[10*i +: 10] !== 10'd250) begin n_err++; $display("FAIL reset_dac2[%0d]: got %0d, required 250", i, Dac2[10*i +: 10]); end
            if (ChipID[8*i +: 8] !== exp_id) begin n_err++; $display("FAIL reset_chipid[%0d]: got %h, required %h", i, ChipID[8*i +: 8], exp_id); end
            if (Ctrl[16*i +: 16] !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl[%0d]: got %h, required 0000", i, Ctrl[16*i +: 16]); end
            if (Mask[192*i +: 192] !== {192{1'b1}}) begin n_err++; $display("FAIL reset_mask[%0d]: got %h, required all ones", i, Mask[192*i +: 192]); end
        end
        n_vec++;
        if ({LoadStart, Busy, LoadCompletePulse, CommitError, Flags, ReadbackValid} !== 12'h000 || ReadbackData !== 16'h0) begin
            n_err++;
            $display("FAIL reset_strobes: got start=%b busy=%b lc=%b ce=%b flags=%b rv=%b rd=%h, required all zero",
                     LoadStart, Busy, LoadCompletePulse, CommitError, Flags, ReadbackValid, ReadbackData);
        end
    endtask

    task automatic test_commit_latency();
        drive_cmd(4'h0, 5'h1F, 16'h0);
        n_vec++;
        if (Busy !== 1'b1 || LoadCompletePulse !== 1'b0) begin n_err++; $display("FAIL latency_t1: got busy=%b lc=%b, required 1/0", Busy, LoadCompletePulse); end
        @(negedge Clk);
        n_vec++;
        if (LoadCompletePulse !== 1'b0) begin n_err++; $display("FAIL latency_t2: got lc=%b, required 0", LoadCompletePulse); end
        @(negedge Clk);
        n_vec++;
        if (LoadCompletePulse !== 1'b1 || Busy !== 1'b1) begin n_err++; $display("FAIL latency_t3: got lc=%b busy=%b, required 1/1", LoadCompletePulse, Busy); end
        @(negedge Clk);
        n_vec++;
        if (Busy !== 1'b0 || LoadCompletePulse !== 1'b0) begin n_err++; $display("FAIL latency_t4: got busy=%b lc=%b, required 0/0", Busy, LoadCompletePulse); end
    endtask

    task automatic test_single_chain();
        drive_cmd(4'd2, 5'h01, 16'h0155);
        n_vec++;
        if (Dac1[29:20] !== 10'd250) begin n_err++; $display("FAIL single_shadow_only: got %h, required %h", Dac1[29:20], 10'd250); end
        exp_q.push_back(4'b0100);
        drive_cmd(4'h0, 5'h1F, 16'h0);
        n_vec++;
        if (Busy !== 1'b1 || Dac1[29:20] !== 10'd250) begin n_err++; $display("FAIL single_t1: got busy=%b dac1=%h, required 1/%h", Busy, Dac1[29:20], 10'd250); end
        @(negedge Clk);
        n_vec++;
        if (Dac1[29:20] !== 10'h155 || Dac1[19:10] !== 10'd250) begin n_err++; $display("FAIL single_t2_dac1: got %h/%h, required 155/%h", Dac1[29:20], Dac1[19:10], 10'd250); end
        serve(2, 5, 0);
        wait_complete();
        n_vec++;
        if (Flags !== 4'b0000) begin n_err++; $display("FAIL single_flags: got %b, required 0000", Flags); end
        @(negedge Clk);
        n_vec++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL single_end: got busy=%b pending=%0d, required 0/0", Busy, exp_q.size()); end
    endtask

    task automatic test_broadcast_mask();
        drive_cmd(4'hF, 5'd19, 16'h00FF);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        drive_cmd(4'h0, 5'h1F, 16'h0);
        serve(0, 3, 1);
        serve(1, 2, 0);
        serve(2, 4, 0);
        serve(3, 1, 0);
        wait_complete();
        @(negedge Clk);
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (Mask[192*i + 176 +: 16] !== 16'h00FF || Mask[192*i +: 176] !== {176{1'b1}}) begin
                n_err++;
                $display("FAIL bcast_mask[%0d]: got %h, required 00FF followed by all ones", i, Mask[192*i +: 192]);
            end
        end
        n_vec++;
        if (Flags !== 4'b0000 || exp_q.size() != 0) begin n_err++; $display("FAIL bcast_end: got flags=%b pending=%0d, required 0000/0", Flags, exp_q.size()); end
    endtask

    task automatic test_timeout();
        drive_cmd(4'd1, 5'h00, 16'h0123);
        drive_cmd(4'd0, 5'h04, 16'hA5C3);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        drive_cmd(4'h0, 5'h1F, 16'h0);
        serve(0, 2, 0);
        wait_start(1);
        repeat (20) @(negedge Clk);
        n_vec++;
        if (Flags !== 4'b0000) begin n_err++; $display("FAIL timeout_early: got %b, required 0000", Flags); end
        @(negedge Clk);
        n_vec++;
        if (Flags !== 4'b0010 || Busy !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got flags=%b busy=%b, required 0010/1", Flags, Busy); end
        wait_complete();
        @(negedge Clk);
        n_vec++;
        if (Flags !== 4'b0010 || Busy !== 1'b0) begin n_err++; $display("FAIL timeout_sticky: got flags=%b busy=%b, required 0010/0", Flags, Busy); end
        n_vec++;
        if (Dac0[19:10] !== 10'h123 || Ctrl[15:0] !== 16'hA5C3) begin n_err++; $display("FAIL timeout_active: got dac0=%h ctrl=%h, required 123/A5C3", Dac0[19:10], Ctrl[15:0]); end
        drive_cmd(4'h0, 5'h1F, 16'h0);
        n_vec++;
        if (Flags !== 4'b0000) begin n_err++; $display("FAIL timeout_clear: got %b, required 0000", Flags); end
        wait_complete();
        @(negedge Clk);
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL timeout_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_busy_commit();
        drive_cmd(4'd3, 5'h02, 16'h00AA);
        exp_q.push_back(4'b1000);
        drive_cmd(4'h0, 5'h1F, 16'h0);
        wait_start(3);
        CmdValid = 1'b1; CmdChain = 4'h0; CmdField = 5'h1F; CmdData = 16'h0;
        @(negedge Clk);
        CmdValid = 1'b0;
        n_vec++;
        if (CommitError !== 1'b1 || Busy !== 1'b1) begin n_err++; $display("FAIL busy_commit_err: got ce=%b busy=%b, required 1/1", CommitError, Busy); end
        @(negedge Clk);
        n_vec++;
        if (CommitError !== 1'b0 || Dac2[39:30] !== 10'h0AA) begin n_err++; $display("FAIL busy_commit_after: got ce=%b dac2=%h, required 0/0AA", CommitError, Dac2[39:30]); end
        LoadDone[3] = 1'b1;
        CmdValid = 1'b1; CmdChain = 4'd3; CmdField = 5'h02; CmdData = 16'h03FF;
        exp_q.push_back(4'b1000);
        @(negedge Clk);
        LoadDone = '0;
        CmdValid = 1'b0;
        serve(3, 2, 0);
        wait_complete();
        @(negedge Clk);
        n_vec++;
        if (Dac2[39:30] !== 10'h0AA || exp_q.size() != 0) begin n_err++; $display("FAIL busy_reload: got dac2=%h pending=%0d, required 0AA/0", Dac2[39:30], exp_q.size()); end
        drive_cmd(4'h0, 5'h1F, 16'h0);
        @(negedge Clk);
        n_vec++;
        if (Dac2[39:30] !== 10'h3FF) begin n_err++; $display("FAIL busy_recommit: got %h, required 3FF", Dac2[39:30]); end
        @(negedge Clk);
        n_vec++;
        if (LoadCompletePulse !== 1'b1) begin n_err++; $display("FAIL busy_recommit_lc: got %b, required 1", LoadCompletePulse); end
        @(negedge Clk);
    endtask

    task automatic test_readback();
        drive_cmd(4'd0, 5'h03, 16'h005A);
        n_vec++;
        if (ChipID[7:0] !== 8'hA1) begin n_err++; $display("FAIL rb_active_unchanged: got %h, required A1", ChipID[7:0]); end
`ifdef MICROROC_PARAM_READBACK_EN
        drive_cmd(4'd0, 5'h1E, 16'd3);
        n_vec++;
        if (ReadbackValid !== 1'b1 || ReadbackData !== 16'h005A) begin n_err++; $display("FAIL rb_chipid: got v=%b d=%h, required 1/005A", ReadbackValid, ReadbackData); end
        @(negedge Clk);
        n_vec++;
        if (ReadbackValid !== 1'b0) begin n_err++; $display("FAIL rb_pulse: got %b, required 0", ReadbackValid); end
        drive_cmd(4'd2, 5'h1E, 16'd19);
        n_vec++;
        if (ReadbackValid !== 1'b1 || ReadbackData !== 16'h00FF) begin n_err++; $display("FAIL rb_mask: got v=%b d=%h, required 1/00FF", ReadbackValid, ReadbackData); end
        drive_cmd(4'd1, 5'h1E, 16'd0);
        n_vec++;
        if (ReadbackValid !== 1'b1 || ReadbackData !== 16'h0123) begin n_err++; $display("FAIL rb_dac0: got v=%b d=%h, required 1/0123", ReadbackValid, ReadbackData); end
        drive_cmd(4'hF, 5'h1E, 16'd3);
        n_vec++;
        if (ReadbackValid !== 1'b1 || ReadbackData !== 16'h0000) begin n_err++; $display("FAIL rb_bcast: got v=%b d=%h, required 1/0000", ReadbackValid, ReadbackData); end
        drive_cmd(4'd0, 5'h1E, 16'd5);
        n_vec++;
        if (ReadbackValid !== 1'b1 || ReadbackData !== 16'h0000) begin n_err++; $display("FAIL rb_badfield: got v=%b d=%h, required 1/0000", ReadbackValid, ReadbackData); end
`else
        drive_cmd(4'd0, 5'h1E, 16'd3);
        n_vec++;
        if (ReadbackValid !== 1'b0 || ReadbackData !== 16'h0000) begin n_err++; $display("FAIL rb_disabled: got v=%b d=%h, required 0/0000", ReadbackValid, ReadbackData); end
`endif
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(4'b0001);
        drive_cmd(4'h0, 5'h1F, 16'h0);
        wait_start(0);
        @(negedge Clk);
        n_vec++;
        if (ChipID[7:0] !== 8'h5A || Busy !== 1'b1) begin n_err++; $display("FAIL midreset_before: got id=%h busy=%b, required 5A/1", ChipID[7:0], Busy); end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (Busy !== 1'b0 || LoadStart !== 4'b0000 || ChipID[7:0] !== 8'hA1 || Dac2[39:30] !== 10'd250 || Flags !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_values: got busy=%b start=%b id=%h dac2=%h flags=%b, required 0/0000/A1/0FA/0000",
                     Busy, LoadStart, ChipID[7:0], Dac2[39:30], Flags);
        end
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        n_vec++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL midreset_after: got busy=%b pending=%0d, required 0/0", Busy, exp_q.size()); end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        reset_n = 1'b1;
        test_reset();
        test_commit_latency();
        test_single_chain();
        test_broadcast_mask();
        test_timeout();
        test_busy_commit();
        test_readback();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
